// File: rtl/nexus_mem_arbiter.sv
// nexus_mem_arbiter: shares one single-port sync RAM between fetch and load/store; NEXUS_BYTE_ACCESS_EN adds byte loads and RMW byte stores
module nexus_mem_arbiter #(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 15,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  ls_req,
  input  logic                  ls_we,
  input  logic [ADDR_WIDTH-1:0] ls_addr,
  input  logic [DATA_WIDTH-1:0] ls_wdata,
  input  logic                  ls_byte,
  input  logic                  ls_bsel,
  output logic                  ls_gnt,
  output logic                  ls_rvalid,
  output logic [DATA_WIDTH-1:0] ls_rdata,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIM = SW'(STARVE_LIMIT);
  logic                  idle, rmw, rmw_wr, byte_req, if_win;
  logic [SW-1:0]         starve;
  logic [ADDR_WIDTH-1:0] rmw_addr;
  logic [DATA_WIDTH-1:0] merged, ld_data;
`ifdef NEXUS_BYTE_ACCESS_EN
  localparam logic [1:0] IDLE = 2'd0, RMW_RD = 2'd1, RMW_WR = 2'd2;
  logic [1:0]  state;
  logic        b_sel, r_byte, r_bsel;
  logic [7:0]  b_data;
  assign idle     = state == IDLE;
  assign rmw_wr   = state == RMW_WR;
  assign rmw      = ~idle;
  assign byte_req = ls_byte;
  // RMW sequencing: latch the byte store at grant, read the word, then write it back merged
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= IDLE;
      rmw_addr <= '0;
      b_sel    <= 1'b0;
      b_data   <= '0;
    end else begin
      state <= (ls_gnt & ls_we & ls_byte) ? RMW_RD : state == RMW_RD ? RMW_WR : IDLE;
      if (ls_gnt & ls_we & ls_byte) begin
        rmw_addr <= ls_addr;
        b_sel    <= ls_bsel;
        b_data   <= ls_wdata[7:0];
      end
    end
  // remember byte-load lane so the returning word can be narrowed
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_byte <= 1'b0;
      r_bsel <= 1'b0;
    end else begin
      r_byte <= ls_gnt & ls_byte;
      r_bsel <= ls_bsel;
    end
  // lane merge for the write-back and lane extract for byte loads
  always_comb begin
    merged = ram_dout;
    merged[{b_sel, 3'b000} +: 8] = b_data;
    ld_data = r_byte ? DATA_WIDTH'(ram_dout[{r_bsel, 3'b000} +: 8]) : ram_dout;
  end
`else
  logic unused_byte;
  assign unused_byte = ls_byte ^ ls_bsel;
  assign idle     = 1'b1;
  assign rmw      = 1'b0;
  assign rmw_wr   = 1'b0;
  assign byte_req = 1'b0;
  assign rmw_addr = ls_addr;
  assign merged   = ls_wdata;
  assign ld_data  = ram_dout;
`endif
  // grant arbitration and RAM port steering
  always_comb begin
    if_win   = idle & if_req & (~ls_req | starve == LIM);
    if_gnt   = rst_n & if_win;
    ls_gnt   = rst_n & idle & ls_req & ~if_win;
    ram_we   = rmw_wr | (ls_gnt & ls_we & ~byte_req);
    ram_addr = rmw ? rmw_addr : ls_gnt ? ls_addr : if_addr;
    ram_din  = rmw_wr ? merged : ls_wdata;
    if_rdata = if_rvalid ? ram_dout : '0;
    ls_rdata = ls_rvalid ? ld_data : '0;
  end
  // read-valid pipeline and fetch starvation counter
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      if_rvalid <= 1'b0;
      ls_rvalid <= 1'b0;
      starve    <= '0;
    end else begin
      if_rvalid <= if_gnt;
      ls_rvalid <= ls_gnt & ~ls_we;
      starve    <= (if_req & ~if_gnt) ? (starve == LIM ? starve : starve + SW'(1)) : '0;
    end
endmodule

// File: tb/tb_nexus_mem_arbiter.sv
// tb_nexus_mem_arbiter: directed scenarios with a cycle model and literal checks; honours NEXUS_BYTE_ACCESS_EN
module tb_nexus_mem_arbiter;
`ifdef NEXUS_BYTE_ACCESS_EN
  localparam bit BYTE_EN = 1'b1;
`else
  localparam bit BYTE_EN = 1'b0;
`endif
  localparam int LIMIT = 4;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        if_req = 0, ls_req = 0, ls_we = 0, ls_byte = 0, ls_bsel = 0;
  logic [14:0] if_addr = '0, ls_addr = '0;
  logic [15:0] ls_wdata = '0;
  logic        if_gnt, if_rvalid, ls_gnt, ls_rvalid, ram_we;
  logic [15:0] if_rdata, ls_rdata, ram_din, ram_dout;
  logic [14:0] ram_addr;
  logic [15:0] mem  [0:32767];
  logic [15:0] refm [0:32767];
  int n_cmp = 0, n_bad = 0;
  byte gtrace[$];
  logic [15:0] ifq[$], lsq[$];
  int starve = 0, busy = 0;
  bit pi = 0, pl = 0;
  logic [15:0] ei, el, bword;
  logic [14:0] baddr;

  nexus_mem_arbiter #(.DATA_WIDTH(16), .ADDR_WIDTH(15), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_byte(ls_byte),
    .ls_bsel(ls_bsel), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    bit e_if, e_ls;
    if (!rst_n) begin
      chk("rst_if_gnt", if_gnt, 0);
      chk("rst_ls_gnt", ls_gnt, 0);
      chk("rst_ram_we", ram_we, 0);
      chk("rst_if_rvalid", if_rvalid, 0);
      chk("rst_ls_rvalid", ls_rvalid, 0);
      chk("rst_if_rdata", if_rdata, 0);
      chk("rst_ls_rdata", ls_rdata, 0);
      starve = 0; busy = 0; pi = 0; pl = 0;
    end else begin
      chk("if_rvalid", if_rvalid, pi);
      if (pi) chk("if_rdata", if_rdata, ei);
      chk("ls_rvalid", ls_rvalid, pl);
      if (pl) chk("ls_rdata", ls_rdata, el);
      pi = 0; pl = 0;
      e_if = busy == 0 && if_req && (!ls_req || starve == LIMIT);
      e_ls = busy == 0 && ls_req && !e_if;
      chk("if_gnt", if_gnt, e_if);
      chk("ls_gnt", ls_gnt, e_ls);
      if (busy == 1) begin
        chk("rmw_we", ram_we, 1);
        chk("rmw_addr", ram_addr, baddr);
        chk("rmw_din", ram_din, bword);
        refm[baddr] = bword;
        busy = 0;
      end else if (busy == 2) begin
        chk("rmw_rd_we", ram_we, 0);
        busy = 1;
      end else if (e_if) begin
        chk("if_ram_addr", ram_addr, if_addr);
        chk("if_ram_we", ram_we, 0);
        pi = 1; ei = refm[if_addr];
      end else if (e_ls) begin
        chk("ls_ram_addr", ram_addr, ls_addr);
        if (ls_we && BYTE_EN && ls_byte) begin
          chk("bst_ram_we", ram_we, 0);
          bword = refm[ls_addr];
          if (ls_bsel) bword[15:8] = ls_wdata[7:0]; else bword[7:0] = ls_wdata[7:0];
          baddr = ls_addr; busy = 2;
        end else if (ls_we) begin
          chk("st_ram_we", ram_we, 1);
          chk("st_ram_din", ram_din, ls_wdata);
          refm[ls_addr] = ls_wdata;
        end else begin
          chk("ld_ram_we", ram_we, 0);
          pl = 1;
          el = !(BYTE_EN && ls_byte) ? refm[ls_addr] :
               ls_bsel ? {8'h00, refm[ls_addr][15:8]} : {8'h00, refm[ls_addr][7:0]};
        end
      end else chk("idle_ram_we", ram_we, 0);
      starve = (if_req && !e_if) ? (starve < LIMIT ? starve + 1 : LIMIT) : 0;
      if (if_gnt) gtrace.push_back("I");
      else if (ls_gnt) gtrace.push_back("L");
      else if (if_req || ls_req) gtrace.push_back("-");
      if (if_rvalid) ifq.push_back(if_rdata);
      if (ls_rvalid) lsq.push_back(ls_rdata);
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr();
    gtrace.delete(); ifq.delete(); lsq.delete();
  endtask

  task automatic exp_trace(input string name, input string s);
    chk({name, "_len"}, gtrace.size(), s.len());
    for (int i = 0; i < s.len() && i < gtrace.size(); i++) chk(name, gtrace[i], s[i]);
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) begin
      mem[i] = 16'h1000 + 16'(i);
      refm[i] = mem[i];
    end
    mem[16'h20] = 16'h1234; refm[16'h20] = 16'h1234;
    if_req = 1; ls_req = 1;
    cyc(3);
    if_req = 0; ls_req = 0;
    rst_n = 1;
    cyc(2);
    // fetch-only streaming
    clr(); if_req = 1;
    for (int a = 0; a < 4; a++) begin
      if_addr = 15'(a);
      cyc();
    end
    if_req = 0; cyc(2);
    exp_trace("fetch_trace", "IIII");
    chk("fetch_cnt", ifq.size(), 4);
    for (int i = 0; i < 4 && i < ifq.size(); i++) chk("fetch_data", ifq[i], 16'h1000 + 16'(i));
    // contention with starvation override
    clr(); ls_req = 1; ls_we = 0; ls_addr = 15'h5; if_req = 1; if_addr = 15'h6;
    cyc(6);
    ls_req = 0; if_req = 0; cyc(2);
    exp_trace("cont_trace", "LLLLIL");
    chk("cont_if_cnt", ifq.size(), 1);
    if (ifq.size() > 0) chk("cont_if_data", ifq[0], 16'h1006);
    chk("cont_ls_cnt", lsq.size(), 5);
    if (lsq.size() > 0) chk("cont_ls_data", lsq[0], 16'h1005);
    // store then fetch to the same address
    clr(); ls_req = 1; ls_we = 1; ls_addr = 15'h10; ls_wdata = 16'hBEEF; if_req = 1; if_addr = 15'h10;
    cyc();
    ls_req = 0; ls_we = 0; cyc();
    if_req = 0; cyc(2);
    exp_trace("stf_trace", "LI");
    chk("stf_cnt", ifq.size(), 1);
    if (ifq.size() > 0) chk("stf_data", ifq[0], 16'hBEEF);
`ifdef NEXUS_BYTE_ACCESS_EN
    // byte store via read-modify-write, then byte load
    clr(); ls_req = 1; ls_we = 1; ls_byte = 1; ls_bsel = 1; ls_addr = 15'h20; ls_wdata = 16'h00AB;
    if_req = 1; if_addr = 15'h20;
    cyc();
    ls_req = 0; ls_we = 0; ls_byte = 0; cyc(3);
    if_req = 0; ls_req = 1; ls_byte = 1; ls_bsel = 0; cyc();
    ls_req = 0; ls_byte = 0; cyc(2);
    exp_trace("bst_trace", "L--IL");
    chk("bst_cnt", ifq.size(), 1);
    if (ifq.size() > 0) chk("bst_word", ifq[0], 16'hAB34);
    chk("bld_cnt", lsq.size(), 1);
    if (lsq.size() > 0) chk("bld_data", lsq[0], 16'h0034);
    // reset in the middle of RMW must not write
    clr(); ls_req = 1; ls_we = 1; ls_byte = 1; ls_bsel = 0; ls_addr = 15'h20; ls_wdata = 16'h00CD;
    cyc();
    rst_n = 0; if_req = 1;
`else
    // byte controls ignored: full-word single-cycle store
    clr(); ls_req = 1; ls_we = 1; ls_byte = 1; ls_bsel = 1; ls_addr = 15'h20; ls_wdata = 16'h00AB;
    if_req = 1; if_addr = 15'h20;
    cyc();
    ls_req = 0; ls_we = 0; ls_byte = 0; cyc();
    if_req = 0; cyc(2);
    exp_trace("wst_trace", "LI");
    chk("wst_cnt", ifq.size(), 1);
    if (ifq.size() > 0) chk("wst_word", ifq[0], 16'h00AB);
    // reset with both requesters active
    clr(); rst_n = 0; if_req = 1; ls_req = 1; ls_we = 1;
`endif
    cyc(2);
    chk("rst_mid_if_gnt", if_gnt, 0);
    chk("rst_mid_ls_gnt", ls_gnt, 0);
    chk("rst_mid_ram_we", ram_we, 0);
    ls_req = 0; ls_we = 0; ls_byte = 0; if_req = 1; if_addr = 15'h20; rst_n = 1;
    cyc();
    if_req = 0; cyc(2);
    chk("post_rst_cnt", ifq.size(), 1);
    if (ifq.size() > 0) chk("post_rst_word", ifq[0], BYTE_EN ? 16'hAB34 : 16'h00AB);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/nexus_mem_arbiter.md
NEXUS_MEM_ARBITER -- requirements
Module: nexus_mem_arbiter

Interface
REQ-001 Parameters SHALL be:
- DATA_WIDTH, default 16, RAM word width.
- ADDR_WIDTH, default 15, RAM word-address width.
- STARVE_LIMIT, default 4, consecutive fetch-denied cycles before fetch priority is forced.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  sole clock; all state updates on its rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- if_req  in  1  instruction-fetch read request.
- if_addr  in  ADDR_WIDTH  fetch word address.
- if_gnt  out  1  fetch request accepted this cycle.
- if_rvalid  out  1  fetch read data valid.
- if_rdata  out  DATA_WIDTH  fetch read data.
- ls_req  in  1  load/store request.
- ls_we  in  1  1 = store, 0 = load.
- ls_addr  in  ADDR_WIDTH  load/store word address.
- ls_wdata  in  DATA_WIDTH  store data (byte stores use bits [7:0]).
- ls_byte  in  1  byte access (used only with NEXUS_BYTE_ACCESS_EN).
- ls_bsel  in  1  byte lane; 0 = [7:0], 1 = [15:8].
- ls_gnt  out  1  load/store request accepted this cycle.
- ls_rvalid  out  1  load data valid.
- ls_rdata  out  DATA_WIDTH  load data.
- ram_we  out  1  to RAM write enable.
- ram_addr  out  ADDR_WIDTH  to RAM address.
- ram_din  out  DATA_WIDTH  to RAM write data.
- ram_dout  in  DATA_WIDTH  from RAM; registered, valid one cycle after the address is presented.

Function
REQ-003 The arbiter SHALL drive one single-port synchronous RAM shared by fetch and load/store, with at most one RAM access per cycle.
REQ-004 Grants SHALL be combinational, issued only in state IDLE, and at most one of if_gnt/ls_gnt SHALL be high per cycle.
REQ-005 Priority in IDLE: ls wins unless the starve counter equals STARVE_LIMIT and if_req=1; in that case fetch wins.
REQ-006 The starve counter SHALL:
- increment (saturating at STARVE_LIMIT) in each cycle where if_req=1 and if_gnt=0;
- clear on if_gnt or when if_req=0.
REQ-007 Requesters SHALL hold address and data stable while req=1 and gnt=0.
REQ-008 On a granted read, ram_addr SHALL equal the winner's address in that cycle. The matching rvalid SHALL pulse exactly one cycle later, with rdata = ram_dout. Latency is 1 cycle and back-to-back reads run at 1 per cycle.
REQ-009 On a granted full-word store, ram_we=1, ram_addr=ls_addr and ram_din=ls_wdata in the grant cycle; ls_rvalid SHALL NOT pulse.
REQ-010 When no grant is issued, ram_we SHALL be 0; ram_addr is don't-care.
REQ-011 The FSM states SHALL be IDLE, RMW_RD and RMW_WR.
- RMW_RD and RMW_WR exist only with NEXUS_BYTE_ACCESS_EN.
- IDLE -> RMW_RD on a granted byte store; the address is read and addr/bsel/wdata[7:0] are latched.
- RMW_RD -> RMW_WR after 1 cycle. In RMW_WR, ram_we=1 and ram_din = ram_dout with the selected lane replaced by the latched byte.
- RMW_WR -> IDLE after 1 cycle.
- No grants are issued in RMW_RD or RMW_WR.
REQ-012 A byte load SHALL return the selected lane zero-extended in ls_rdata; the lane is taken from a bsel value registered at grant.
REQ-013 A fetch and a store to the same address requested in the same cycle: the store SHALL be granted first (per REQ-005), and the later fetch SHALL return the new data.

Reset
REQ-014 While rst_n=0, all of the following SHALL hold:
- state = IDLE;
- starve counter = 0;
- if_rvalid = 0 and ls_rvalid = 0;
- if_gnt = 0, ls_gnt = 0 and ram_we = 0;
- if_rdata and ls_rdata = 0.
REQ-015 Reset asserted during RMW_RD or RMW_WR SHALL abort the operation with no RAM write; operation resumes in IDLE on the first clk edge after rst_n rises.

Configuration
REQ-016 With macro NEXUS_BYTE_ACCESS_EN defined, byte loads and read-modify-write byte stores SHALL operate per REQ-011/REQ-012.
REQ-017 Without NEXUS_BYTE_ACCESS_EN:
- ls_byte and ls_bsel SHALL be ignored and all accesses are full-word single-cycle;
- the FSM reduces to IDLE only.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- Fetch-only: if_req=1, addrs 0x0000..0x0003 (RAM preloaded with 0x1000+addr) -> if_gnt every cycle; if_rvalid 1 cycle later with 0x1000..0x1003 consecutively.
- Contention: if_req and ls_req (load) held high for 6 cycles, STARVE_LIMIT=4 -> 4 ls grants, then 1 if grant, then ls; never both gnts high.
- Store then fetch: ls store 0xBEEF to 0x0010 with if_req to 0x0010 in the same cycle -> ls_gnt first; the fetch returns 0xBEEF.
- Byte store (macro on): word 0x1234 at 0x0020, byte store 0xAB with bsel=1 -> 3-cycle busy, no grants in RMW_RD/RMW_WR; the word becomes 0xAB34; a byte load with bsel=0 returns 0x0034.
- Reset during RMW_RD -> word at 0x0020 unchanged; all outputs 0 while rst_n=0.
- Macro off: byte store 0x00AB with bsel=1 to 0x0020 -> full word written as 0x00AB in 1 cycle.
